// File: rtl/tabela_verdade_sequenciador_if.sv
// Evaluator/command bundle for the truth-table sweep controller.
// With TT_GOLDEN_CHECK_EN defined the bundle also carries golden and golden_err.
interface tabela_verdade_sequenciador_if #(
   parameter int N_VARS = 4
);
   localparam int TW = 2 ** N_VARS;

   logic              start;
   logic              abort;
   logic [N_VARS-1:0] vec_out;
   logic              s_min_in;
   logic              s_max_in;
   logic              busy;
   logic              done;
   logic [TW-1:0]     table_min;
   logic [TW-1:0]     table_max;
   logic              mismatch;
   logic [N_VARS-1:0] mismatch_idx;
`ifdef TT_GOLDEN_CHECK_EN
   logic [TW-1:0]     golden;
   logic              golden_err;

   modport slave (
      input  start, abort, s_min_in, s_max_in, golden,
      output vec_out, busy, done, table_min, table_max, mismatch, mismatch_idx, golden_err
   );
   modport master (
      output start, abort, s_min_in, s_max_in, golden,
      input  vec_out, busy, done, table_min, table_max, mismatch, mismatch_idx, golden_err
   );
`else
   modport slave (
      input  start, abort, s_min_in, s_max_in,
      output vec_out, busy, done, table_min, table_max, mismatch, mismatch_idx
   );
   modport master (
      output start, abort, s_min_in, s_max_in,
      input  vec_out, busy, done, table_min, table_max, mismatch, mismatch_idx
   );
`endif
endinterface

// File: rtl/tabela_verdade_sequenciador.sv
// Sweeps every input vector of an SOP/POS evaluator, records both truth tables and the first
// disagreement. Optional golden-table compare is built when TT_GOLDEN_CHECK_EN is defined.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_IDLE | waiting for start; tables and flags hold their last values
//  ST_WAIT | vec_out applied; settle countdown, then sample both outputs
//  ST_DONE | one-cycle completion pulse, then back to ST_IDLE
module tabela_verdade_sequenciador #(
   parameter int N_VARS        = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   tabela_verdade_sequenciador_if.slave  bus
);
   localparam int                TW      = 2 ** N_VARS;
   localparam logic [3:0]        SETTLE  = 4'(SETTLE_CYCLES);
   localparam logic [N_VARS-1:0] VEC_END = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [N_VARS-1:0] vec_q, vec_nx;
   logic [3:0]        cnt_q, cnt_nx;
   logic [TW-1:0]     tmin_q, tmin_nx;
   logic [TW-1:0]     tmax_q, tmax_nx;
   logic              mm_q, mm_nx;
   logic [N_VARS-1:0] mm_idx_q, mm_idx_nx;
`ifdef TT_GOLDEN_CHECK_EN
   logic              gerr_q, gerr_nx;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         vec_q    <= '0;
         cnt_q    <= '0;
         tmin_q   <= '0;
         tmax_q   <= '0;
         mm_q     <= 1'b0;
         mm_idx_q <= '0;
`ifdef TT_GOLDEN_CHECK_EN
         gerr_q   <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         vec_q    <= vec_nx;
         cnt_q    <= cnt_nx;
         tmin_q   <= tmin_nx;
         tmax_q   <= tmax_nx;
         mm_q     <= mm_nx;
         mm_idx_q <= mm_idx_nx;
`ifdef TT_GOLDEN_CHECK_EN
         gerr_q   <= gerr_nx;
`endif
      end
   end

   always_comb begin
      state_nx  = state;
      vec_nx    = vec_q;
      cnt_nx    = cnt_q;
      tmin_nx   = tmin_q;
      tmax_nx   = tmax_q;
      mm_nx     = mm_q;
      mm_idx_nx = mm_idx_q;
`ifdef TT_GOLDEN_CHECK_EN
      gerr_nx   = gerr_q;
`endif
      case (state)
         ST_IDLE: begin
            // abort outranks start, so a simultaneous pair leaves everything untouched
            if (!bus.abort && bus.start) begin
               vec_nx    = '0;
               cnt_nx    = SETTLE;
               tmin_nx   = '0;
               tmax_nx   = '0;
               mm_nx     = 1'b0;
               mm_idx_nx = '0;
`ifdef TT_GOLDEN_CHECK_EN
               gerr_nx   = 1'b0;
`endif
               state_nx  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.abort) begin
               state_nx = ST_IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_nx = cnt_q - 4'd1;
            end else begin
               tmin_nx[vec_q] = bus.s_min_in;
               tmax_nx[vec_q] = bus.s_max_in;
               if ((bus.s_min_in != bus.s_max_in) && !mm_q) begin
                  mm_nx     = 1'b1;
                  mm_idx_nx = vec_q;
               end
               if (vec_q == VEC_END) begin
                  state_nx = ST_DONE;
               end else begin
                  vec_nx = vec_q + 1'b1;
                  cnt_nx = SETTLE;
               end
            end
         end
         ST_DONE: begin
`ifdef TT_GOLDEN_CHECK_EN
            gerr_nx  = (tmin_q != bus.golden);
`endif
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign bus.vec_out      = vec_q;
   assign bus.busy         = (state == ST_WAIT);
   assign bus.done         = (state == ST_DONE);
   assign bus.table_min    = tmin_q;
   assign bus.table_max    = tmax_q;
   assign bus.mismatch     = mm_q;
   assign bus.mismatch_idx = mm_idx_q;
`ifdef TT_GOLDEN_CHECK_EN
   assign bus.golden_err   = gerr_q;
`endif

endmodule

// File: tb/tb_tabela_verdade_sequenciador.sv
// Bench for the truth-table sweep controller: two instances (settle 1 and settle 0) share stimulus
// and are compared against a table-level reference model of the sweep.
module tb_tabela_verdade_sequenciador;
   localparam int N  = 4;
   localparam int TW = 16;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [TW-1:0] f_min;
   logic [TW-1:0] f_max;
   int            n_checks;
   int            n_fail;
`ifdef TT_GOLDEN_CHECK_EN
   logic [TW-1:0] golden;
`endif

   tabela_verdade_sequenciador_if #(.N_VARS(N)) bus1 ();
   tabela_verdade_sequenciador_if #(.N_VARS(N)) bus0 ();

   tabela_verdade_sequenciador #(.N_VARS(N), .SETTLE_CYCLES(1)) u_dut_s1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );
   tabela_verdade_sequenciador #(.N_VARS(N), .SETTLE_CYCLES(0)) u_dut_s0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   // evaluator model: the truth functions are plain lookup tables indexed by the applied vector
   assign bus1.start    = start;
   assign bus1.abort    = abort;
   assign bus1.s_min_in = f_min[bus1.vec_out];
   assign bus1.s_max_in = f_max[bus1.vec_out];
   assign bus0.start    = start;
   assign bus0.abort    = abort;
   assign bus0.s_min_in = f_min[bus0.vec_out];
   assign bus0.s_max_in = f_max[bus0.vec_out];
`ifdef TT_GOLDEN_CHECK_EN
   assign bus1.golden   = golden;
   assign bus0.golden   = golden;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected sweep outcome: vector k is captured at cycle k*(s+1)+s+1, and an abort in cycle ab
   // suppresses every capture at or after ab.
   function automatic void model(input int s, input int ab,
                                 output logic [TW-1:0] tmin, output logic [TW-1:0] tmax,
                                 output logic mm, output logic [N-1:0] idx, output logic [N-1:0] vec);
      tmin = '0;
      tmax = '0;
      mm   = 1'b0;
      idx  = '0;
      for (int k = 0; k < TW; k++) begin
         if (ab == 0 || (k * (s + 1) + s + 1) < ab) begin
            tmin[k] = f_min[k];
            tmax[k] = f_max[k];
            if (f_min[k] != f_max[k] && !mm) begin
               mm  = 1'b1;
               idx = N'(k);
            end
         end
      end
      vec = (ab == 0) ? N'(TW - 1) : N'((ab - 1) / (s + 1));
   endfunction

   task automatic check_results(input string tag, input int s, input int ab,
                                input logic [TW-1:0] tmin, input logic [TW-1:0] tmax,
                                input logic mm, input logic [N-1:0] idx, input logic [N-1:0] vec,
                                input logic gerr);
      logic [TW-1:0] e_tmin, e_tmax;
      logic          e_mm;
      logic [N-1:0]  e_idx, e_vec;
      model(s, ab, e_tmin, e_tmax, e_mm, e_idx, e_vec);
      check($sformatf("%s_table_min", tag), 32'(tmin), 32'(e_tmin));
      check($sformatf("%s_table_max", tag), 32'(tmax), 32'(e_tmax));
      check($sformatf("%s_mismatch", tag), 32'(mm), 32'(e_mm));
      check($sformatf("%s_mismatch_idx", tag), 32'(idx), 32'(e_idx));
      check($sformatf("%s_vec_out", tag), 32'(vec), 32'(e_vec));
`ifdef TT_GOLDEN_CHECK_EN
      check($sformatf("%s_golden_err", tag), 32'(gerr), (ab == 0) ? 32'(f_min != golden) : 32'd0);
`else
      if (gerr !== 1'b0) check($sformatf("%s_golden_absent", tag), 32'(gerr), 32'd0);
`endif
   endtask

   // Starts both instances in cycle 0 and tracks them for 40 cycles; optional abort in cycle ab and
   // optional start re-pulses in cycles 5 and 17 that must be ignored.
   task automatic run_sweep(input string tag, input bit repulse, input int ab);
      logic g1, g0;
      start = 1'b1;
      abort = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         step();
         start = repulse && (cyc == 5 || cyc == 17);
         abort = (ab != 0) && (cyc == ab);
         check($sformatf("%s_s1_busy_c%0d", tag, cyc), 32'(bus1.busy),
               32'(cyc >= 1 && cyc <= TW * 2 && (ab == 0 || cyc <= ab)));
         check($sformatf("%s_s1_done_c%0d", tag, cyc), 32'(bus1.done), 32'(ab == 0 && cyc == TW * 2 + 1));
         check($sformatf("%s_s0_busy_c%0d", tag, cyc), 32'(bus0.busy),
               32'(cyc >= 1 && cyc <= TW && (ab == 0 || cyc <= ab)));
         check($sformatf("%s_s0_done_c%0d", tag, cyc), 32'(bus0.done), 32'(ab == 0 && cyc == TW + 1));
      end
      start = 1'b0;
      abort = 1'b0;
`ifdef TT_GOLDEN_CHECK_EN
      g1 = bus1.golden_err;
      g0 = bus0.golden_err;
`else
      g1 = 1'b0;
      g0 = 1'b0;
`endif
      check_results({tag, "_s1"}, 1, ab, bus1.table_min, bus1.table_max, bus1.mismatch,
                    bus1.mismatch_idx, bus1.vec_out, g1);
      check_results({tag, "_s0"}, 0, ab, bus0.table_min, bus0.table_max, bus0.mismatch,
                    bus0.mismatch_idx, bus0.vec_out, g0);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_s1_busy"}, 32'(bus1.busy), 32'd0);
      check({tag, "_s1_done"}, 32'(bus1.done), 32'd0);
      check({tag, "_s1_vec"}, 32'(bus1.vec_out), 32'd0);
      check({tag, "_s1_tmin"}, 32'(bus1.table_min), 32'd0);
      check({tag, "_s1_tmax"}, 32'(bus1.table_max), 32'd0);
      check({tag, "_s1_mm"}, 32'(bus1.mismatch), 32'd0);
      check({tag, "_s1_idx"}, 32'(bus1.mismatch_idx), 32'd0);
      check({tag, "_s0_busy"}, 32'(bus0.busy), 32'd0);
      check({tag, "_s0_tmin"}, 32'(bus0.table_min), 32'd0);
      check({tag, "_s0_mm"}, 32'(bus0.mismatch), 32'd0);
`ifdef TT_GOLDEN_CHECK_EN
      check({tag, "_s1_gerr"}, 32'(bus1.golden_err), 32'd0);
`endif
   endtask

   initial begin
      logic [TW-1:0] hold_min, hold_max;
      n_checks = 0;
      n_fail   = 0;
      start    = 1'b0;
      abort    = 1'b0;
      f_min    = '0;
      f_max    = '0;
`ifdef TT_GOLDEN_CHECK_EN
      golden   = 16'h0800;
`endif
      rst_n    = 1'b0;
      step();
      step();
      check_cleared("reset");
      rst_n = 1'b1;
      step();

      // A & ~B & C & D is true only for vector 4'b1011; repulses at 5 and 17 must be ignored
      f_min = 16'h0800;
      f_max = 16'h0800;
      run_sweep("t2", 1'b1, 0);
      check("t2_tmin_const", 32'(bus1.table_min), 32'h0800);

      f_max = 16'h0000;
      run_sweep("t3", 1'b0, 0);
      check("t3_idx_const", 32'(bus1.mismatch_idx), 32'hB);

      // start and abort together in IDLE: nothing may change
      hold_min = bus1.table_min;
      hold_max = bus1.table_max;
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("idle_sa_busy", 32'(bus1.busy), 32'd0);
      step();
      check("idle_sa_busy2", 32'(bus1.busy), 32'd0);
      check("idle_sa_tmin", 32'(bus1.table_min), 32'(hold_min));
      check("idle_sa_tmax", 32'(bus1.table_max), 32'(hold_max));
      check("idle_sa_mm", 32'(bus1.mismatch), 32'd1);

      f_max = 16'h0800;
      run_sweep("t4_abort", 1'b0, 10);
      run_sweep("t4_restart", 1'b0, 0);

      // asynchronous reset in cycle 7 of a sweep
      start = 1'b1;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         step();
         start = 1'b0;
      end
      check("t1_busy_before", 32'(bus1.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_cleared("t1");
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("t1_idle_after", 32'(bus1.busy), 32'd0);
      check("t1_idle_after_s0", 32'(bus0.busy), 32'd0);

`ifdef TT_GOLDEN_CHECK_EN
      f_min  = 16'h0800;
      f_max  = 16'h0800;
      golden = 16'h0800;
      run_sweep("t6_ok", 1'b0, 0);
      golden = 16'h0801;
      run_sweep("t6_bad", 1'b0, 0);
`endif

      for (int it = 0; it < 8; it++) begin
         int ab;
         f_min = 16'($urandom);
         f_max = ($urandom_range(0, 2) == 0) ? f_min : (f_min ^ (16'($urandom) & 16'($urandom)));
         ab = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 16));
`ifdef TT_GOLDEN_CHECK_EN
         golden = ($urandom_range(0, 1) == 0) ? f_min : (f_min ^ (16'd1 << $urandom_range(0, 15)));
`endif
         run_sweep($sformatf("rnd%0d", it), (ab == 0) && ($urandom_range(0, 1) == 1), ab);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
